string_match_counter: RTL and testbench

Parametrised successor to the single-character string detector. It counts occurrences of a programmable multi-byte pattern, up to PAT_LEN bytes long, inside length-prefixed frames delivered one byte per valid strobe by the serial receiver. At end of frame it reports the count with a completion pulse, then re-arms for the next frame without software intervention. It sits between the UART receiver byte output and the status/transmit logic.

---
 rtl/string_match_pkg.sv | 25 ++
 rtl/match_window.sv | 88 ++++++++
 rtl/string_match_counter.sv | 133 +++++++++++++
 tb/tb_string_match_counter.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/string_match_pkg.sv
// rtl/string_match_pkg.sv - shared types and defaults for the string match counter
//
// Purpose : frame FSM state type, default parameter values and the
//           pattern-length legality helper used by string_match_counter.
// Ports   : none (package).
package string_match_pkg;

  // Frame FSM: waiting for a length header, or consuming payload bytes.
  typedef enum logic {
    IDLE    = 1'b0,
    PAYLOAD = 1'b1
  } state_t;

  localparam int SMC_DATA_W  = 8;
  localparam int SMC_PAT_LEN = 4;
  localparam int SMC_LEN_W   = 8;
  localparam int SMC_CNT_W   = 8;

  // A pattern length is usable only if it is 1..max_len.
  function automatic logic pat_len_illegal(input int unsigned len,
                                           input int unsigned max_len);
    return (len == 0) || (len > max_len);
  endfunction

endpackage

// File: rtl/match_window.sv
// rtl/match_window.sv - sliding byte window with masked pattern compare
//
// Purpose : keeps the last PAT_LEN payload bytes and a fill count, and flags
//           a hit when the newest i_pat_len bytes equal the pattern.
// Config  : STRING_MATCH_OVERLAP_EN defined keeps the fill on a hit
//           (overlapping matches); undefined clears it (non-overlapping).
// Ports   : i_clk, i_rst_n   clock, async active-low reset
//           i_clear          restart window fill (frame header accepted)
//           i_shift          accept i_byte into the window this cycle
//           i_byte           incoming payload byte
//           i_pattern        pattern, byte 0 at [DATA_W-1:0]
//           i_pat_len        latched active pattern length
//           i_enable         compare allowed (configuration legal)
//           o_hit            single-cycle hit for the byte shifted this cycle
module match_window
  import string_match_pkg::*;
#(
  parameter int DATA_W  = SMC_DATA_W,
  parameter int PAT_LEN = SMC_PAT_LEN,
  parameter int PL_W    = $clog2(SMC_PAT_LEN + 1)
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_clear,
  input  logic                        i_shift,
  input  logic [DATA_W-1:0]           i_byte,
  input  logic [PAT_LEN*DATA_W-1:0]   i_pattern,
  input  logic [PL_W-1:0]             i_pat_len,
  input  logic                        i_enable,
  output logic                        o_hit
);

  // r_win[0] is the newest byte, r_win[PAT_LEN-1] the oldest.
  logic [DATA_W-1:0] r_win      [PAT_LEN];
  logic [DATA_W-1:0] w_next_win [PAT_LEN];
  logic [PL_W-1:0]   r_fill;
  logic [PL_W-1:0]   w_next_fill;
  logic              w_eq;
  int                w_k;

  always_comb begin
    w_next_win[0] = i_byte;
    for (int i = 1; i < PAT_LEN; i++) begin
      w_next_win[i] = r_win[i-1];
    end
  end

  assign w_next_fill = (r_fill == PL_W'(PAT_LEN)) ? r_fill : r_fill + 1'b1;

  // Pattern byte j (arrival order) must sit at window slot k-1-j, i.e. the
  // oldest of the k newest bytes is pattern byte 0. Slots beyond k are masked.
  always_comb begin
    w_k  = int'(i_pat_len);
    w_eq = 1'b1;
    for (int j = 0; j < PAT_LEN; j++) begin
      for (int i = 0; i < PAT_LEN; i++) begin
        if ((j < w_k) && (i + j + 1 == w_k) &&
            (w_next_win[i] != i_pattern[j*DATA_W +: DATA_W])) begin
          w_eq = 1'b0;
        end
      end
    end
  end

  assign o_hit = i_shift && i_enable && (w_next_fill >= i_pat_len) && w_eq;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_fill <= '0;
      for (int i = 0; i < PAT_LEN; i++) begin
        r_win[i] <= '0;
      end
    end else if (i_clear) begin
      r_fill <= '0;
    end else if (i_shift) begin
      for (int i = 0; i < PAT_LEN; i++) begin
        r_win[i] <= w_next_win[i];
      end
`ifdef STRING_MATCH_OVERLAP_EN
      r_fill <= w_next_fill;
`else
      // A counted match consumes its bytes; the next one needs fresh bytes.
      r_fill <= o_hit ? '0 : w_next_fill;
`endif
    end
  end

endmodule

// File: rtl/string_match_counter.sv
// rtl/string_match_counter.sv - counts pattern matches inside length-prefixed frames
//
// Purpose : first valid byte of a frame is its payload length; payload bytes
//           are searched for a programmable pattern of up to PAT_LEN bytes.
//           At end of frame o_done pulses and the block re-arms by itself.
// Config  : STRING_MATCH_OVERLAP_EN (see match_window) selects overlapping
//           match counting; default is non-overlapping.
// Ports   : i_clk, i_rst_n   clock, async active-low reset
//           i_byte_in        received byte
//           i_byte_valid     byte strobe, one byte per cycle
//           i_pattern        pattern bytes, byte 0 at [DATA_W-1:0]
//           i_pat_len        active pattern length, latched at header
//           o_count          matches in current/last frame (saturating)
//           o_busy           frame payload in progress
//           o_done           one-cycle end-of-frame pulse
//           o_sat            count saturated in this frame
//           o_cfg_err        latched pattern length was 0 or > PAT_LEN
module string_match_counter
  import string_match_pkg::*;
#(
  parameter int DATA_W  = SMC_DATA_W,
  parameter int PAT_LEN = SMC_PAT_LEN,
  parameter int LEN_W   = SMC_LEN_W,
  parameter int CNT_W   = SMC_CNT_W
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic [DATA_W-1:0]             i_byte_in,
  input  logic                          i_byte_valid,
  input  logic [PAT_LEN*DATA_W-1:0]     i_pattern,
  input  logic [$clog2(PAT_LEN+1)-1:0]  i_pat_len,
  output logic [CNT_W-1:0]              o_count,
  output logic                          o_busy,
  output logic                          o_done,
  output logic                          o_sat,
  output logic                          o_cfg_err
);

  localparam int PL_W = $clog2(PAT_LEN + 1);

  state_t                      r_state;
  logic [LEN_W-1:0]            r_len;
  logic [PL_W-1:0]             r_pat_len;
  logic [PAT_LEN*DATA_W-1:0]   r_pattern;
  logic [CNT_W-1:0]            r_count;
  logic                        r_busy;
  logic                        r_done;
  logic                        r_sat;
  logic                        r_cfg_err;

  logic                        w_header;
  logic                        w_shift;
  logic                        w_hit;

  assign w_header = (r_state == IDLE)    && i_byte_valid;
  assign w_shift  = (r_state == PAYLOAD) && i_byte_valid;

  match_window #(
    .DATA_W  (DATA_W),
    .PAT_LEN (PAT_LEN),
    .PL_W    (PL_W)
  ) u_match_window (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_clear   (w_header),
    .i_shift   (w_shift),
    .i_byte    (i_byte_in),
    .i_pattern (r_pattern),
    .i_pat_len (r_pat_len),
    .i_enable  (!r_cfg_err),
    .o_hit     (w_hit)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= IDLE;
      r_len     <= '0;
      r_pat_len <= '0;
      r_pattern <= '0;
      r_count   <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_sat     <= 1'b0;
      r_cfg_err <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_byte_valid) begin
            // Header: pattern configuration is frozen for the whole frame.
            r_len     <= LEN_W'(i_byte_in);
            r_pat_len <= i_pat_len;
            r_pattern <= i_pattern;
            r_count   <= '0;
            r_sat     <= 1'b0;
            r_cfg_err <= pat_len_illegal(int'(i_pat_len), PAT_LEN);
            if (i_byte_in != '0) begin
              r_state <= PAYLOAD;
              r_busy  <= 1'b1;
            end else begin
              r_done  <= 1'b1;
            end
          end
        end
        PAYLOAD: begin
          if (i_byte_valid) begin
            r_len <= r_len - 1'b1;
            if (w_hit) begin
              if (r_count == '1) begin
                r_sat <= 1'b1;
              end else begin
                r_count <= r_count + 1'b1;
              end
            end
            if (r_len == LEN_W'(1)) begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_count   = r_count;
  assign o_busy    = r_busy;
  assign o_done    = r_done;
  assign o_sat     = r_sat;
  assign o_cfg_err = r_cfg_err;

endmodule

// File: tb/tb_string_match_counter.sv
// tb/tb_string_match_counter.sv - self-checking bench for string_match_counter
module tb_string_match_counter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  i_byte_in;
  logic        i_byte_valid;
  logic [31:0] i_pattern;
  logic [2:0]  i_pat_len;

  logic [7:0]  o_count;
  logic        o_busy, o_done, o_sat, o_cfg_err;
  logic [1:0]  s_count;
  logic        s_busy, s_done, s_sat, s_cfg_err;

  int total = 0;
  int bad   = 0;
  logic [7:0] payload[$];

  always #5 clk = ~clk;

  string_match_counter #(.DATA_W(8), .PAT_LEN(4), .LEN_W(8), .CNT_W(8)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_byte_in(i_byte_in), .i_byte_valid(i_byte_valid),
    .i_pattern(i_pattern), .i_pat_len(i_pat_len), .o_count(o_count), .o_busy(o_busy),
    .o_done(o_done), .o_sat(o_sat), .o_cfg_err(o_cfg_err));

  string_match_counter #(.DATA_W(8), .PAT_LEN(4), .LEN_W(8), .CNT_W(2)) dut_s (
    .i_clk(clk), .i_rst_n(rst_n), .i_byte_in(i_byte_in), .i_byte_valid(i_byte_valid),
    .i_pattern(i_pattern), .i_pat_len(i_pat_len), .o_count(s_count), .o_busy(s_busy),
    .o_done(s_done), .o_sat(s_sat), .o_cfg_err(s_cfg_err));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit v, input logic [7:0] b);
    i_byte_valid = v;
    i_byte_in    = b;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_cnt"},  o_count, 0);   chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_done"}, o_done, 0);    chk({tag, "_sat"},  o_sat, 0);
    chk({tag, "_cfg"},  o_cfg_err, 0); chk({tag, "_scnt"}, s_count, 0);
    chk({tag, "_sbusy"}, s_busy, 0);   chk({tag, "_ssat"}, s_sat, 0);
  endtask

  // Sends the header (payload length) then the payload queue. Expected counts
  // come from searching the bytes seen so far for the latched pattern.
  task automatic run_frame(input string tag, input logic [31:0] pat, input int k,
                           input int gmax, input bit mutate, input bit idle_after);
    int  len, exp, last_end;
    bit  cfg, hit;
    len = payload.size();
    cfg = (k == 0) || (k > 4);
    exp = 0;
    last_end = -1;
    i_pattern = pat;
    i_pat_len = 3'(k);
    step(1'b1, 8'(len));
    chk({tag, "_hdr_busy"}, o_busy, 32'(len != 0));
    chk({tag, "_hdr_done"}, o_done, 32'(len == 0));
    chk({tag, "_hdr_cnt"},  o_count, 0);
    chk({tag, "_hdr_cfg"},  o_cfg_err, 32'(cfg));
    chk({tag, "_hdr_sat"},  s_sat, 0);
    for (int p = 0; p < len; p++) begin
      repeat ($urandom_range(gmax, 0)) begin
        if (mutate) begin
          i_pattern = $urandom;
          i_pat_len = 3'($urandom_range(7, 0));
        end
        step(1'b0, 8'($urandom));
        chk({tag, "_gap_done"}, o_done, 0);
        chk({tag, "_gap_cnt"},  o_count, 32'(exp));
      end
      step(1'b1, payload[p]);
      hit = 1'b0;
      if (!cfg && (p + 1 >= k)) begin
        hit = 1'b1;
        for (int j = 0; j < k; j++) begin
          if (payload[p-k+1+j] != pat[8*j +: 8]) hit = 1'b0;
        end
`ifndef STRING_MATCH_OVERLAP_EN
        if (p - last_end < k) hit = 1'b0;
`endif
      end
      if (hit) begin
        exp++;
        last_end = p;
      end
      chk({tag, "_cnt"},  o_count, 32'((exp > 255) ? 255 : exp));
      chk({tag, "_scnt"}, s_count, 32'((exp > 3) ? 3 : exp));
      chk({tag, "_ssat"}, s_sat,   32'(exp > 3));
      chk({tag, "_done"}, o_done,  32'(p == len - 1));
      chk({tag, "_busy"}, o_busy,  32'(p != len - 1));
    end
    chk({tag, "_end_cfg"}, s_cfg_err, 32'(cfg));
    if (idle_after) begin
      step(1'b0, 8'($urandom));
      chk({tag, "_idle_done"}, o_done, 0);
      chk({tag, "_idle_busy"}, o_busy, 0);
      chk({tag, "_idle_cnt"},  o_count, 32'(exp));
    end
  endtask

  initial begin
    rst_n = 1'b0;
    i_byte_valid = 1'b0;
    i_byte_in = 8'h00;
    i_pattern = 32'h0;
    i_pat_len = 3'd0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    rst_n = 1'b1;
    step(1'b0, 8'h00);

    payload = '{8'h41, 8'h42, 8'h41, 8'h42, 8'h41, 8'h42};
    run_frame("ab", 32'h4241, 2, 0, 1'b0, 1'b1);

    payload = '{8'h41, 8'h41, 8'h41, 8'h41};
    run_frame("aa", 32'h4141, 2, 1, 1'b0, 1'b0);

    // Zero-length frame followed back-to-back by a one-byte frame.
    payload.delete();
    run_frame("zero", 32'h41, 1, 0, 1'b0, 1'b0);
    payload = '{8'h41};
    run_frame("one", 32'h41, 1, 0, 1'b0, 1'b1);

    payload = '{8'h41, 8'h41, 8'h41, 8'h41, 8'h41};
    run_frame("sat", 32'h41, 1, 0, 1'b0, 1'b1);
    chk("sat_flag", s_sat, 1);
    chk("sat_wide_flag", o_sat, 0);

    payload = '{8'h41, 8'h41};
    run_frame("cfg5", 32'h41414141, 5, 0, 1'b0, 1'b1);
    chk("cfg5_err", o_cfg_err, 1);
    payload = '{8'h41};
    run_frame("cfg0", 32'h41, 0, 0, 1'b0, 1'b0);

    for (int f = 0; f < 25; f++) begin
      logic [31:0] pat;
      int k, len;
      pat = 32'h0;
      for (int j = 0; j < 4; j++) pat[8*j +: 8] = $urandom_range(1, 0) ? 8'h41 : 8'h42;
      k   = ($urandom_range(9, 0) == 0) ? $urandom_range(7, 0) : $urandom_range(4, 1);
      len = $urandom_range(20, 0);
      payload.delete();
      for (int b = 0; b < len; b++) payload.push_back($urandom_range(1, 0) ? 8'h41 : 8'h42);
      run_frame("rand", pat, k, 2, 1'b1, $urandom_range(1, 0) == 1);
    end

    // Reset in the middle of a 5-byte frame.
    i_pattern = 32'h41;
    i_pat_len = 3'd1;
    step(1'b1, 8'd5);
    step(1'b1, 8'h41);
    step(1'b1, 8'h41);
    chk("prerst_cnt", o_count, 2);
    chk("prerst_busy", o_busy, 1);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("midrst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    payload = '{8'h41};
    run_frame("postrst", 32'h41, 1, 0, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
